// File: rtl/addr_signed_serial_rchk.sv
// Digit-serial signed adder: CHUNK bits per cycle, exact WIDTH+1-bit sum,
// guarded by a mod-3 residue check with automatic bounded re-execution.
module addr_signed_serial_rchk #(
  parameter int WIDTH     = 8,
  parameter int CHUNK     = 4,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inj_en,
  input  logic [WIDTH:0]   inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  generate
    if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1 || MAX_RETRY < 0) begin : g_bad_param
      $error("addr_signed_serial_rchk: WIDTH must be >=2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [TRY_W-1:0] r_tries;
  logic [WIDTH:0]   r_sum;
  logic             r_err;
  logic [CNT_W-1:0] r_fault_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_match;
  logic             w_can_retry;
  logic [CHUNK:0]   w_chunk;
  logic [WIDTH:0]   w_sum_nxt;
  logic [1:0]       w_res_ab;
  logic [1:0]       w_res_sum;

  // Modular add of two residues already in 0..2.
  function automatic logic [1:0] mod3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    logic [2:0] d;
    // NOTE: blocking assignments are correct inside functions and always_comb;
    // only clocked state below uses non-blocking assignments.
    s = {1'b0, x} + {1'b0, y};
    d = s - 3'd3;
    return (s >= 3'd3) ? d[1:0] : s[1:0];
  endfunction

  // Residue of a signed (WIDTH+1)-bit value: bit i weighs 2^i mod 3 (1,2,1,...),
  // the sign bit weighs -2^WIDTH mod 3.
  function automatic logic [1:0] res3(input logic [WIDTH:0] x);
    logic [1:0] acc;
    acc = 2'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) acc = mod3_add(acc, (i % 2 == 0) ? 2'd1 : 2'd2);
    end
    if (x[WIDTH]) acc = mod3_add(acc, (WIDTH % 2 == 0) ? 2'd2 : 2'd1);
    return acc;
  endfunction

  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_idx == IDX_W'(NCH - 1));
  assign w_chunk     = {1'b0, r_a[r_idx*CHUNK +: CHUNK]}
                     + {1'b0, r_b[r_idx*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, r_carry};
  assign w_res_ab    = mod3_add(res3({r_a[WIDTH-1], r_a}), res3({r_b[WIDTH-1], r_b}));
  assign w_res_sum   = res3(r_sum);
  assign w_match     = (w_res_ab == w_res_sum);
  assign w_can_retry = (int'(r_tries) < MAX_RETRY);

  // Merge the current chunk into the running sum; the final chunk also fixes
  // the sign bit and applies any fault-injection mask to the whole word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_sum_nxt = r_sum;
    w_sum_nxt[r_idx*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
    if (w_last) begin
      w_sum_nxt[WIDTH] = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_chunk[CHUNK];
      if (inj_en) w_sum_nxt = w_sum_nxt ^ inj_mask;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch here.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !rst;
        if (w_accept) w_state_nxt = S_ADD;
      end
      S_ADD: begin
        if (w_last) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_match || !w_can_retry) w_state_nxt = S_DONE;
        else                         w_state_nxt = S_ADD;
      end
      S_DONE: begin
        out_valid = !rst;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_tries     <= '0;
      r_sum       <= '0;
      r_err       <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_tries <= '0;
            r_err   <= 1'b0;
          end
        end
        S_ADD: begin
          r_sum   <= w_sum_nxt;
          r_carry <= w_chunk[CHUNK];
          r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        S_CHECK: begin
          if (w_match) begin
            r_err <= 1'b0;
          end else begin
            if (r_fault_cnt != '1) r_fault_cnt <= r_fault_cnt + CNT_W'(1);
            if (w_can_retry) begin
              r_tries <= r_tries + TRY_W'(1);
              r_idx   <= '0;
              r_carry <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign err       = r_err;
  assign fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_addr_signed_serial_rchk.sv
// Bench for addr_signed_serial_rchk: directed cases and random sweeps on an
// 8-bit instance, plus a 1000-pair random sweep on a 16-bit instance.
module tb_addr_signed_serial_rchk;

  logic clk;
  logic rst;

  logic        in_valid8, in_ready8, inj_en8, out_valid8, out_ready8, err8;
  logic [7:0]  a8, b8;
  logic [8:0]  inj_mask8, sum8;
  logic [15:0] fcnt8;

  logic        in_valid16, in_ready16, inj_en16, out_valid16, out_ready16, err16;
  logic [15:0] a16, b16;
  logic [16:0] inj_mask16, sum16;
  logic [15:0] fcnt16;

  int n_vec;
  int n_bad;
  int exp_fcnt8;

  addr_signed_serial_rchk #(.WIDTH(8), .CHUNK(4), .MAX_RETRY(2), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .inj_en(inj_en8), .inj_mask(inj_mask8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .err(err8),
    .fault_cnt(fcnt8)
  );

  addr_signed_serial_rchk #(.WIDTH(16), .CHUNK(4), .MAX_RETRY(2), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .inj_en(inj_en16), .inj_mask(inj_mask16),
    .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16), .err(err16),
    .fault_cnt(fcnt16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int res3(input int x);
    return ((x % 3) + 3) % 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit operation; cyc returns the cycle (accept = 0) in which
  // out_valid is first seen. inj_en is held for cycles 1..inj_last.
  task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input bit inj,
                         input logic [8:0] mask, input int inj_last, output int cyc);
    int guard;
    guard = 0;
    while (!in_ready8 && guard < 50) begin tick(); guard++; end
    if (!in_ready8) check("in_ready8_timeout", {31'd0, in_ready8}, 32'd1);
    a8 = ia; b8 = ib; inj_mask8 = mask; inj_en8 = inj; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    cyc = 1;
    while (!out_valid8 && cyc < 200) begin
      inj_en8 = inj && (cyc <= inj_last);
      tick();
      cyc++;
    end
    inj_en8 = 1'b0;
    if (!out_valid8) check("out_valid8_timeout", {31'd0, out_valid8}, 32'd1);
  endtask

  task automatic pop8();
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("out_valid8_drop", {31'd0, out_valid8}, 32'd0);
  endtask

  // Model of one operation taken straight from the arithmetic: the written sum
  // is (a+b) xor mask; a residue mismatch repeats every attempt while inj holds.
  task automatic model_op8(input logic [7:0] ia, input logic [7:0] ib, input bit inj,
                           input logic [8:0] mask, output logic [8:0] e_sum,
                           output bit e_err, output int e_cyc);
    int s;
    logic [8:0] w;
    bit ok;
    s = int'($signed(ia)) + int'($signed(ib));
    w = 9'(s);
    if (inj) w = w ^ mask;
    ok = ((res3(int'($signed(ia))) + res3(int'($signed(ib)))) % 3) == res3(int'($signed(w)));
    e_sum = w;
    e_err = !ok;
    e_cyc = ok ? 4 : 4 + 2 * 3;
    if (!ok) exp_fcnt8 += 3;
  endtask

  initial begin
    int cyc;
    logic [8:0] e_sum;
    bit e_err;
    int e_cyc;

    n_vec = 0; n_bad = 0; exp_fcnt8 = 0;
    rst = 1'b1;
    in_valid8 = 0; a8 = 0; b8 = 0; inj_en8 = 0; inj_mask8 = 0; out_ready8 = 0;
    in_valid16 = 0; a16 = 0; b16 = 0; inj_en16 = 0; inj_mask16 = 0; out_ready16 = 0;

    tick();
    check("rst_in_ready", {31'd0, in_ready8}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_sum", {23'd0, sum8}, 32'd0);
    check("rst_err", {31'd0, err8}, 32'd0);
    check("rst_fault_cnt", {16'd0, fcnt8}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready8}, 32'd1);

    // 127 + 127
    run_op8(8'd127, 8'd127, 1'b0, 9'h000, 0, cyc);
    check("max_pos_sum", {23'd0, sum8}, 32'h0FE);
    check("max_pos_err", {31'd0, err8}, 32'd0);
    check("max_pos_lat", cyc, 32'd4);
    check("max_pos_fcnt", {16'd0, fcnt8}, 32'd0);
    check("done_in_ready", {31'd0, in_ready8}, 32'd0);
    pop8();

    // -128 + -128, then -1 + 1
    run_op8(8'h80, 8'h80, 1'b0, 9'h000, 0, cyc);
    check("max_neg_sum", {23'd0, sum8}, 32'h100);
    check("max_neg_err", {31'd0, err8}, 32'd0);
    pop8();
    run_op8(8'hFF, 8'h01, 1'b0, 9'h000, 0, cyc);
    check("zero_sum", {23'd0, sum8}, 32'h000);
    check("zero_err", {31'd0, err8}, 32'd0);
    pop8();

    // Fault on the first attempt only: one retry recovers.
    run_op8(8'd100, 8'(-27), 1'b1, 9'h001, 2, cyc);
    exp_fcnt8 = 1;
    check("retry_sum", {23'd0, sum8}, 32'd73);
    check("retry_err", {31'd0, err8}, 32'd0);
    check("retry_fcnt", {16'd0, fcnt8}, exp_fcnt8);
    check("retry_lat", cyc, 32'd7);
    pop8();

    // Persistent fault: all three attempts fail.
    run_op8(8'd5, 8'd6, 1'b1, 9'h010, 1000, cyc);
    exp_fcnt8 += 3;
    check("persist_sum", {23'd0, sum8}, 32'd27);
    check("persist_err", {31'd0, err8}, 32'd1);
    check("persist_fcnt", {16'd0, fcnt8}, exp_fcnt8);
    check("persist_lat", cyc, 32'd10);

    // Back-pressure in DONE: outputs hold, new operands ignored.
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'b1;
      tick();
      check("stall_valid", {31'd0, out_valid8}, 32'd1);
      check("stall_sum", {23'd0, sum8}, 32'd27);
      check("stall_err", {31'd0, err8}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready8}, 32'd0);
    end
    in_valid8 = 1'b0;
    pop8();
    check("stall_release_in_ready", {31'd0, in_ready8}, 32'd1);

    // Random 8-bit operations, some with a persistent injected fault.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] ra, rb;
      logic [8:0] rm;
      bit rinj;
      ra = 8'($urandom); rb = 8'($urandom);
      rinj = ($urandom_range(0, 3) == 0);
      rm = 9'($urandom_range(1, 511));
      model_op8(ra, rb, rinj, rm, e_sum, e_err, e_cyc);
      run_op8(ra, rb, rinj, rm, 1000, cyc);
      check("rnd8_sum", {23'd0, sum8}, {23'd0, e_sum});
      check("rnd8_err", {31'd0, err8}, {31'd0, e_err});
      check("rnd8_lat", cyc, e_cyc);
      check("rnd8_fcnt", {16'd0, fcnt8}, exp_fcnt8);
      pop8();
    end

    // Reset during ADD aborts the operation and clears the fault counter.
    a8 = 8'd3; b8 = 8'd4; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    exp_fcnt8 = 0;
    check("abort_out_valid", {31'd0, out_valid8}, 32'd0);
    check("abort_fcnt", {16'd0, fcnt8}, exp_fcnt8);
    check("abort_in_ready", {31'd0, in_ready8}, 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (out_valid8) seen++; end
      check("abort_no_result", seen, 32'd0);
    end
    run_op8(8'(-50), 8'd20, 1'b0, 9'h000, 0, cyc);
    check("after_abort_sum", {23'd0, sum8}, 32'h1E2);
    check("after_abort_lat", cyc, 32'd4);
    pop8();

    // 16-bit sweep, no injection.
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra, rb;
      int guard, c16, s;
      ra = 16'($urandom); rb = 16'($urandom);
      s = int'($signed(ra)) + int'($signed(rb));
      guard = 0;
      while (!in_ready16 && guard < 50) begin tick(); guard++; end
      if (!in_ready16) check("in_ready16_timeout", {31'd0, in_ready16}, 32'd1);
      a16 = ra; b16 = rb; in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      c16 = 1;
      while (!out_valid16 && c16 < 200) begin tick(); c16++; end
      if (!out_valid16) check("out_valid16_timeout", {31'd0, out_valid16}, 32'd1);
      check("rnd16_sum", {15'd0, sum16}, {15'd0, 17'(s)});
      check("rnd16_err", {31'd0, err16}, 32'd0);
      if (n % 100 == 0) check("rnd16_lat", c16, 32'd6);
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
    end
    check("rnd16_fcnt", {16'd0, fcnt16}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
